// File: rtl/lcd_hd44780_responder.sv
// Device-side HD44780 character LCD model: decodes controller bus cycles, keeps an
// 80-byte DDRAM with address counter and busy flag, answers reads, exposes DDRAM for debug.
module lcd_hd44780_responder #(
  parameter int unsigned BUSY_CYCLES  = 2000,
  parameter int unsigned CLEAR_CYCLES = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] LCD_DATA,
  input  logic       LCD_RW,
  input  logic       LCD_EN,
  input  logic       LCD_RS,
  input  logic       LCD_ON,
  output logic [7:0] lcd_data_o,
  output logic       lcd_data_oe,
  input  logic [6:0] dbg_addr,
  output logic [7:0] dbg_data,
  output logic       busy,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       entry_inc,
  output logic       two_line,
  output logic       protocol_err
);

  localparam int unsigned MAXC = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {S_CLEAR, S_BUSY, S_IDLE} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          sweep, sweep_n;
  logic [6:0]    ac, ac_n;
  logic          disp_n, curs_n, blink_n, inc_n, two_n, perr_n;
  logic          en_q, fall;
  logic          mem_we;
  logic [6:0]    mem_idx;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem [0:79];
  logic [7:0]    ac_map, dbg_map;

  // Returns {mapped, linear index} for an HD44780 DDRAM address.
  function automatic logic [7:0] ddram_map(input logic [6:0] a);
    if (a <= 7'h27)                    return {1'b1, a};
    else if (a >= 7'h40 && a <= 7'h67) return {1'b1, a - 7'h18};
    else                               return 8'h00;
  endfunction

  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
    if (inc) begin
      if (a == 7'h27)      return 7'h40;
      else if (a == 7'h67) return 7'h00;
      else                 return a + 7'd1;
    end else begin
      if (a == 7'h40)      return 7'h27;
      else if (a == 7'h00) return 7'h67;
      else                 return a - 7'd1;
    end
  endfunction

  assign ac_map      = ddram_map(ac);
  assign dbg_map     = ddram_map(dbg_addr);
  assign fall        = en_q & ~LCD_EN & LCD_ON;
  assign busy        = (state != S_IDLE);
  assign lcd_data_oe = LCD_EN & LCD_RW & LCD_ON;

  always_comb begin
    lcd_data_o = {busy, ac};
    if (LCD_RS) lcd_data_o = ac_map[7] ? mem[ac_map[6:0]] : 8'h20;
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    sweep_n   = sweep;
    ac_n      = ac;
    disp_n    = display_on;
    curs_n    = cursor_on;
    blink_n   = blink_on;
    inc_n     = entry_inc;
    two_n     = two_line;
    perr_n    = protocol_err;
    mem_we    = 1'b0;
    mem_idx   = ac_map[6:0];
    mem_wdata = LCD_DATA;
    unique case (state)
      S_CLEAR: begin
        if (sweep && cnt < CW'(80)) begin
          mem_we    = 1'b1;
          mem_idx   = cnt[6:0];
          mem_wdata = 8'h20;
        end
        if (cnt == CW'(CLEAR_CYCLES - 1)) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_BUSY: begin
        if (cnt == '0) state_n = S_IDLE;
        else           cnt_n   = cnt - CW'(1);
      end
      default: begin
        if (fall) begin
          state_n = S_BUSY;
          cnt_n   = CW'(BUSY_CYCLES - 1);
          unique case ({LCD_RS, LCD_RW})
            2'b00: begin
              casez (LCD_DATA)
                8'b1???????: ac_n = LCD_DATA[6:0];
                8'b01??????: ;
                8'b001?????: two_n = LCD_DATA[3];
                8'b0001????: ;
                8'b00001???: begin
                  disp_n  = LCD_DATA[2];
                  curs_n  = LCD_DATA[1];
                  blink_n = LCD_DATA[0];
                end
                8'b000001??: inc_n = LCD_DATA[1];
                8'b0000001?: begin
                  ac_n    = '0;
                  state_n = S_CLEAR;
                  sweep_n = 1'b0;
                  cnt_n   = '0;
                end
                8'b00000001: begin
                  ac_n    = '0;
                  inc_n   = 1'b1;
                  state_n = S_CLEAR;
                  sweep_n = 1'b1;
                  cnt_n   = '0;
                end
                default: begin
                  state_n = S_IDLE;
                  cnt_n   = cnt;
                end
              endcase
            end
            2'b10: begin
              mem_we = ac_map[7];
              ac_n   = ac_step(ac, entry_inc);
            end
            2'b11: ac_n = ac_step(ac, entry_inc);
            default: begin
              state_n = S_IDLE;
              cnt_n   = cnt;
            end
          endcase
        end
      end
    endcase
    // Status reads are the only access tolerated while busy.
    if (fall && state != S_IDLE && !(!LCD_RS && LCD_RW)) perr_n = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_CLEAR;
      cnt          <= '0;
      sweep        <= 1'b1;
      ac           <= '0;
      display_on   <= 1'b0;
      cursor_on    <= 1'b0;
      blink_on     <= 1'b0;
      entry_inc    <= 1'b1;
      two_line     <= 1'b0;
      protocol_err <= 1'b0;
      en_q         <= 1'b0;
      dbg_data     <= 8'h20;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      sweep        <= sweep_n;
      ac           <= ac_n;
      display_on   <= disp_n;
      cursor_on    <= curs_n;
      blink_on     <= blink_n;
      entry_inc    <= inc_n;
      two_line     <= two_n;
      protocol_err <= perr_n;
      en_q         <= LCD_EN;
      dbg_data     <= dbg_map[7] ? mem[dbg_map[6:0]] : 8'h20;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_idx] <= mem_wdata;
  end

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Directed bench for lcd_hd44780_responder with short busy/clear timings.
module tb_lcd_hd44780_responder;
  localparam int unsigned BC = 4;
  localparam int unsigned CC = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] LCD_DATA;
  logic       LCD_RW, LCD_EN, LCD_RS, LCD_ON;
  logic [7:0] lcd_data_o;
  logic       lcd_data_oe;
  logic [6:0] dbg_addr;
  logic [7:0] dbg_data;
  logic       busy, display_on, cursor_on, blink_on, entry_inc, two_line, protocol_err;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  lcd_hd44780_responder #(.BUSY_CYCLES(BC), .CLEAR_CYCLES(CC)) dut (
    .clk(clk), .rst(rst), .LCD_DATA(LCD_DATA), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN),
    .LCD_RS(LCD_RS), .LCD_ON(LCD_ON), .lcd_data_o(lcd_data_o), .lcd_data_oe(lcd_data_oe),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .busy(busy), .display_on(display_on),
    .cursor_on(cursor_on), .blink_on(blink_on), .entry_inc(entry_inc), .two_line(two_line),
    .protocol_err(protocol_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic rs, input logic rw, input logic [7:0] d);
    LCD_RS = rs; LCD_RW = rw; LCD_DATA = d; LCD_EN = 1'b1;
    tick();
    LCD_EN = 1'b0;
    tick();
    LCD_RW = 1'b0;
  endtask

  task automatic busy_len(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 1000) begin
      cnt++;
      tick();
    end
  endtask

  task automatic wr(input logic rs, input logic [7:0] d, output int cnt);
    bus(rs, 1'b0, d);
    busy_len(cnt);
  endtask

  task automatic status(input string tag, input logic [7:0] exp);
    LCD_RS = 1'b0; LCD_RW = 1'b1; LCD_EN = 1'b1;
    #1;
    chk({tag, "_oe_hi"}, lcd_data_oe, 1);
    chk(tag, lcd_data_o, exp);
    tick();
    LCD_EN = 1'b0;
    #1;
    chk({tag, "_oe_lo"}, lcd_data_oe, 0);
    tick();
    LCD_RW = 1'b0;
  endtask

  task automatic dbg(input logic [6:0] a, input logic [7:0] exp);
    dbg_addr = a;
    tick();
    chk($sformatf("dbg_%02h", a), dbg_data, exp);
  endtask

  initial begin
    rst = 1'b1; LCD_DATA = '0; LCD_RW = 1'b0; LCD_EN = 1'b0; LCD_RS = 1'b0;
    LCD_ON = 1'b1; dbg_addr = '0;
    tick(); tick();
    chk("rst_busy", busy, 1);
    chk("rst_disp", {display_on, cursor_on, blink_on}, 0);
    chk("rst_inc", entry_inc, 1);
    chk("rst_two", two_line, 0);
    chk("rst_perr", protocol_err, 0);
    chk("rst_oe", lcd_data_oe, 0);
    chk("rst_dbg", dbg_data, 8'h20);
    rst = 1'b0;
    busy_len(n);
    chk("reset_clear_len", n, CC);
    dbg(7'h00, 8'h20); dbg(7'h27, 8'h20); dbg(7'h40, 8'h20); dbg(7'h67, 8'h20);
    status("st_init", 8'h00);

    wr(1'b0, 8'h38, n);
    chk("fs_busy_len", n, BC);
    chk("two_line", two_line, 1);
    wr(1'b0, 8'h0E, n);
    chk("dc_busy_len", n, BC);
    chk("dcb", {display_on, cursor_on, blink_on}, 3'b110);

    wr(1'b0, 8'h80, n);
    wr(1'b1, 8'h48, n);
    wr(1'b1, 8'h49, n);
    dbg(7'h00, 8'h48); dbg(7'h01, 8'h49);
    status("st_ac02", 8'h02);

    wr(1'b0, 8'hA7, n);
    wr(1'b1, 8'h41, n);
    wr(1'b1, 8'h42, n);
    dbg(7'h27, 8'h41); dbg(7'h40, 8'h42);
    status("st_ac41", 8'h41);

    wr(1'b0, 8'hC0, n);
    wr(1'b0, 8'h04, n);
    chk("entry_dec", entry_inc, 0);
    wr(1'b1, 8'h43, n);
    status("st_ac27", 8'h27);
    LCD_RS = 1'b1; LCD_RW = 1'b1; LCD_EN = 1'b1;
    #1;
    chk("dread_data", lcd_data_o, 8'h41);
    tick();
    LCD_EN = 1'b0;
    tick();
    LCD_RW = 1'b0;
    busy_len(n);
    chk("dread_busy_len", n, BC);
    status("st_ac26", 8'h26);
    wr(1'b0, 8'h80, n);
    wr(1'b1, 8'h50, n);
    status("st_ac67", 8'h67);
    wr(1'b0, 8'h06, n);
    wr(1'b1, 8'h51, n);
    status("st_ac00", 8'h00);
    dbg(7'h67, 8'h51); dbg(7'h00, 8'h50); dbg(7'h40, 8'h43);

    bus(1'b0, 1'b0, 8'h85);
    bus(1'b1, 1'b0, 8'h55);
    chk("perr_set", protocol_err, 1);
    busy_len(n);
    status("st_ac05", 8'h05);
    dbg(7'h05, 8'h20);
    wr(1'b0, 8'h06, n);
    chk("perr_sticky", protocol_err, 1);

    wr(1'b1, 8'h77, n);
    wr(1'b0, 8'h02, n);
    chk("home_len", n, CC);
    status("st_home", 8'h00);
    dbg(7'h05, 8'h77);

    wr(1'b0, 8'h04, n);
    wr(1'b0, 8'h01, n);
    chk("clear_len", n, CC);
    chk("clear_inc", entry_inc, 1);
    status("st_clear", 8'h00);
    dbg(7'h00, 8'h20); dbg(7'h05, 8'h20); dbg(7'h27, 8'h20);
    dbg(7'h40, 8'h20); dbg(7'h67, 8'h20);

    wr(1'b1, 8'h33, n);
    bus(1'b0, 1'b0, 8'h01);
    repeat (30) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    busy_len(n);
    chk("rst_mid_len", n, CC);
    chk("rst_mid_perr", protocol_err, 0);
    chk("rst_mid_disp", display_on, 0);
    dbg(7'h00, 8'h20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lcd_hd44780_responder.md
Name: lcd_hd44780_responder

Overview:
- Device-side model of the HD44780-style character LCD that our LCD controller drives over LCD_DATA/LCD_RW/LCD_EN/LCD_RS/LCD_ON.
- Decodes controller bus cycles, executes the instruction subset we use and maintains an 80-byte DDRAM with address counter and busy flag.
- Answers status and data reads on the bus, and exposes DDRAM contents on a debug port.
- Synthesizable: used in the controller benches and as an on-FPGA loopback target.

Parameters:
BUSY_CYCLES, 2000, busy duration in clk cycles after a normal instruction or data write/read (40 us @ 50 MHz)
CLEAR_CYCLES, 82000, busy duration after clear display or return home; must be >= 80

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
LCD_DATA  in  8  bus data from controller
LCD_RW  in  1  1 = read, 0 = write
LCD_EN  in  1  enable strobe; cycle executes on falling edge
LCD_RS  in  1  0 = instruction/status, 1 = data
LCD_ON  in  1  panel power; 0 = bus ignored
lcd_data_o  out  8  read data driven back to controller
lcd_data_oe  out  1  lcd_data_o valid / tristate enable
dbg_addr  in  7  DDRAM address for debug read (HD44780 address space)
dbg_data  out  8  DDRAM[dbg_addr], registered, 1-cycle latency
busy  out  1  busy flag (BF)
display_on, cursor_on, blink_on  out  1 each  display control bits D, C, B
entry_inc  out  1  I/D bit
two_line  out  1  N bit of function set
protocol_err  out  1  sticky: access attempted while busy

Behaviour:
- Clock: single clock clk. Reset: rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values: AC=0, display_on=0, cursor_on=0, blink_on=0, entry_inc=1, two_line=0, protocol_err=0, lcd_data_oe=0, dbg_data=0x20.
- After reset the block enters CLEAR with busy=1.
- DDRAM linear index mapping:
  - addr 0x00-0x27 -> index addr.
  - addr 0x40-0x67 -> index addr-0x18.
  - Any other address is unmapped: writes are dropped, reads return 0x20.
- EN falling edge is detected as en_q=1 and LCD_EN=0, where en_q is LCD_EN registered.
  - RS, RW and DATA are sampled in that same cycle.
  - Effects are visible the next cycle.
  - Edges are ignored while LCD_ON=0.
- States:
  - CLEAR: writes 0x20 to index ptr, ptr 0..79, one entry per cycle. It then continues counting until CLEAR_CYCLES total cycles have elapsed, then goes to IDLE. busy=1 throughout.
  - BUSY: down-counter loaded with BUSY_CYCLES-1; goes to IDLE when it reaches 0. busy=1.
  - IDLE: busy=0; accepts bus cycles.
- Instruction writes (RS=0, RW=0) in IDLE are decoded by the highest set bit:
  - 1xxxxxxx set DDRAM addr: AC=DATA[6:0].
  - 01xxxxxx CGRAM addr: no effect.
  - 001xxxxx function set: two_line=DATA[3].
  - 0001xxxx shift: no effect.
  - 00001DCB: display_on=D, cursor_on=C, blink_on=B.
  - 000001Ix: entry_inc=I.
  - 0000001x return home: AC=0, go to CLEAR-length busy with no sweep.
  - 00000001 clear: AC=0, entry_inc=1, go to CLEAR with sweep.
  - 0x00: no-op, no busy.
  - Every other instruction goes to BUSY.
- Data write (RS=1, RW=0) in IDLE: write DDRAM[AC] if mapped, step AC, go to BUSY.
- AC step:
  - Increment: 0x27->0x40, 0x67->0x00, unmapped n -> n+1 mod 128.
  - Decrement: 0x40->0x27, 0x00->0x67, unmapped n -> n-1 mod 128.
- Reads:
  - lcd_data_oe = LCD_EN & LCD_RW & LCD_ON (combinational).
  - Status read (RS=0) returns {busy, AC}; it is legal in any state and causes no state change.
  - Data read (RS=1) returns DDRAM[AC]. In IDLE it steps AC at the EN fall and goes to BUSY.
- Any write, or any data read, at an EN fall in CLEAR or BUSY: ignored, and protocol_err<=1 (sticky until rst).
- rst mid-CLEAR or mid-BUSY restarts CLEAR from ptr=0.
- dbg port is independent of bus state. A same-cycle bus write to the dbg address returns the old data.

Test Plan:
- Reset with CLEAR_CYCLES=100, BUSY_CYCLES=4 -> busy=1 for exactly 100 cycles; dbg_data=0x20 for dbg_addr 0x00, 0x27, 0x40, 0x67.
- Write instr 0x38 then 0x0E (each after busy clears) -> two_line=1, display_on=1, cursor_on=1, blink_on=0; busy high 4 cycles after each EN fall.
- Write instr 0x80, data 0x48, data 0x49 -> dbg 0x00=0x48, 0x01=0x49; status read returns 0x02 with lcd_data_oe=1 only while EN high.
- Instr 0xA7 then data 0x41 and 0x42 -> dbg 0x27=0x41, 0x40=0x42, AC=0x41; entry mode 0x04 from AC=0x40 then data write -> AC=0x27.
- Data write 0x55 issued while busy=1 -> DDRAM unchanged, AC unchanged, protocol_err=1 and remains 1.
- Instr 0x01 after filling text -> busy 100 cycles, all mapped DDRAM=0x20, AC=0, entry_inc=1; rst asserted mid-sweep restarts the full 100-cycle CLEAR.
